// File: rtl/instr_reader.sv
// Sweeps an entry range of the instruction register and presents each entry on a valid/ready port.
// Define CHECK_RESULT_EN to add result checking (mismatch, err_count).
package instr_reader_pkg;

    typedef logic [4:0]         address_t;
    typedef logic signed [31:0] operand_t;

    typedef enum logic [2:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef struct packed {
        opcode_t     opc;
        operand_t    op_a;
        operand_t    op_b;
        logic [63:0] result;
    } instruction_t;

endpackage

module instr_reader
    import instr_reader_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  address_t             first_ptr,
    input  address_t             last_ptr,
    output address_t             read_pointer,
    input  instruction_t         instruction_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output instruction_t         out_word,
    output address_t             out_index,
    output logic                 busy,
    output logic                 done
`ifdef CHECK_RESULT_EN
    ,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    if (ERR_CNT_W == 0) begin : g_bad_err_cnt_w
        $error("ERR_CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StRead, StSend, StFinish} state_t;

    state_t       state_q, state_d;
    address_t     ptr_q, ptr_d;
    address_t     last_q, last_d;
    instruction_t word_q, word_d;
    address_t     index_q, index_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        word_d  = word_q;
        index_d = index_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d   = first_ptr;
                    last_d  = last_ptr;
                    state_d = StRead;
                end
            end
            StRead: begin
                word_d  = instruction_word;
                index_d = ptr_q;
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (ptr_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        // 5-bit add wraps 31 -> 0 for free
                        ptr_d   = ptr_q + 5'd1;
                        state_d = StRead;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            last_q  <= '0;
            word_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            word_q  <= word_d;
            index_q <= index_d;
        end
    end

    // ptr only moves on entry to READ, so it doubles as the held read address
    assign read_pointer = ptr_q;
    assign out_valid    = (state_q == StSend);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFinish);
    assign out_word     = word_q;
    assign out_index    = index_q;

`ifdef CHECK_RESULT_EN
    function automatic logic [63:0] expected_result(instruction_t w);
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] r;
        a = {{32{w.op_a[31]}}, w.op_a};
        b = {{32{w.op_b[31]}}, w.op_b};
        case (w.opc)
            ZERO:    r = '0;
            PASSA:   r = a;
            PASSB:   r = b;
            ADD:     r = a + b;
            SUB:     r = a - b;
            MULT:    r = a * b;
            DIV:     r = (b == 0) ? '0 : a / b;
            MOD:     r = (b == 0) ? '0 : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic                 mismatch_q, mismatch_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        if (state_q == StRead) begin
            mismatch_d = (instruction_word.result != expected_result(instruction_word));
        end
        if ((state_q == StSend) && out_ready && mismatch_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_instr_reader.sv
// Randomized self-checking bench for instr_reader with a queue-free sweep model.
// Checks mismatch/err_count too when CHECK_RESULT_EN is defined.
module tb_instr_reader;
    import instr_reader_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     first_ptr;
    address_t     last_ptr;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    address_t     out_index;
    logic         busy;
    logic         done;
`ifdef CHECK_RESULT_EN
    logic         mismatch;
    logic [7:0]   err_count;
    int           exp_err = 0;
`endif

    instruction_t mem [32];
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    always_comb instruction_word = mem[read_pointer];

    instr_reader #(.ERR_CNT_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_ptr        (first_ptr),
        .last_ptr         (last_ptr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word         (out_word),
        .out_index        (out_index),
        .busy             (busy),
        .done             (done)
`ifdef CHECK_RESULT_EN
        ,
        .mismatch         (mismatch),
        .err_count        (err_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_result(instruction_t w);
        longint a = w.op_a;
        longint b = w.op_b;
        case (w.opc)
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? 64'd0 : a / b;
            MOD:     return (b == 0) ? 64'd0 : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic instruction_t make_instr(opcode_t o, int a, int b, bit correct);
        instruction_t w;
        w.opc    = o;
        w.op_a   = a;
        w.op_b   = b;
        w.result = model_result(w);
        if (!correct) w.result = w.result ^ (64'd1 << $urandom_range(0, 63));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem[i] = make_instr(opcode_t'($urandom_range(0, 7)), int'($urandom),
                                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom),
                                $urandom_range(0, 3) != 0);
        end
    endtask

    // stall >= 0 holds out_ready low that many SEND cycles; stall < 0 picks 0..3 at random
    task automatic run_sweep(input address_t f, input address_t l, input int stall, input bit noisy);
        int       n;
        int       s;
        address_t idx;
        address_t nxt;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        start = 1'b1; first_ptr = f; last_ptr = l;
        tick();
        start = 1'b0; first_ptr = address_t'($urandom); last_ptr = address_t'($urandom);
        check_eq("start_busy", busy, 1'b1);
        check_eq("start_no_valid", out_valid, 1'b0);
        check_eq("start_read_ptr", read_pointer, f);
        for (int k = 0; k < n; k++) begin
            idx = address_t'((int'(f) + k) % 32);
            if (noisy) out_ready = 1'($urandom_range(0, 1));
            tick();
            out_ready = 1'b0;
            check_eq("send_valid", out_valid, 1'b1);
            check_eq("send_index", out_index, idx);
            check_eq("send_word", out_word, mem[idx]);
`ifdef CHECK_RESULT_EN
            check_eq("send_mismatch", mismatch, mem[idx].result != model_result(mem[idx]));
`endif
            s = (stall >= 0) ? stall : $urandom_range(0, 3);
            for (int j = 0; j < s; j++) begin
                if (noisy) start = 1'($urandom_range(0, 1));
                tick();
                start = 1'b0;
                check_eq("stall_valid", out_valid, 1'b1);
                check_eq("stall_index", out_index, idx);
                check_eq("stall_word", out_word, mem[idx]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
`ifdef CHECK_RESULT_EN
            if (mem[idx].result != model_result(mem[idx]) && exp_err < 255) exp_err++;
            check_eq("err_count", err_count, exp_err);
`endif
            if (k == n - 1) begin
                check_eq("finish_done", done, 1'b1);
                check_eq("finish_valid", out_valid, 1'b0);
                tick();
                check_eq("idle_done", done, 1'b0);
                check_eq("idle_busy", busy, 1'b0);
            end else begin
                nxt = address_t'((int'(idx) + 1) % 32);
                check_eq("read_done", done, 1'b0);
                check_eq("read_valid", out_valid, 1'b0);
                check_eq("read_ptr", read_pointer, nxt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; first_ptr = '0; last_ptr = '0;
        fill_random();
        #2;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_read_ptr", read_pointer, 5'd0);
        check_eq("rst_index", out_index, 5'd0);
        check_eq("rst_word", out_word, 131'd0);
`ifdef CHECK_RESULT_EN
        check_eq("rst_mismatch", mismatch, 1'b0);
        check_eq("rst_err_count", err_count, 8'd0);
`endif
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // ADD 5,3 / SUB 5,3 / MULT -2,7 / DIV 9,0 -> 8, 2, -14, 0
        mem[0] = make_instr(ADD, 5, 3, 1'b1);
        mem[1] = make_instr(SUB, 5, 3, 1'b1);
        mem[2] = make_instr(MULT, -2, 7, 1'b1);
        mem[3] = make_instr(DIV, 9, 0, 1'b1);
        check_eq("vec_add", mem[0].result, 64'd8);
        check_eq("vec_mult", mem[2].result, 64'hFFFF_FFFF_FFFF_FFF2);
        run_sweep(5'd0, 5'd3, 0, 1'b0);

        fill_random();
        run_sweep(5'd30, 5'd1, -1, 1'b1);
        run_sweep(5'd5, 5'd4, -1, 1'b1);
        run_sweep(5'd17, 5'd17, 10, 1'b1);

`ifdef CHECK_RESULT_EN
        mem[10]        = make_instr(ADD, 5, 3, 1'b1);
        mem[10].result = 64'd9;
        mem[11]        = make_instr(SUB, 5, 3, 1'b1);
        run_sweep(5'd10, 5'd11, 0, 1'b0);
`endif

        // reset during SEND of entry 2 of 4
        for (int i = 0; i < 4; i++) mem[i] = make_instr(ADD, i, 1, 1'b1);
        start = 1'b1; first_ptr = 5'd0; last_ptr = 5'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        tick();
        check_eq("pre_rst_index", out_index, 5'd2);
        check_eq("pre_rst_valid", out_valid, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_read_ptr", read_pointer, 5'd0);
        check_eq("mid_rst_word", out_word, 131'd0);
`ifdef CHECK_RESULT_EN
        exp_err = 0;
        check_eq("mid_rst_err_count", err_count, 8'd0);
`endif
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_done", done, 1'b0);
            check_eq("post_rst_busy", busy, 1'b0);
        end

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_sweep(address_t'($urandom), address_t'($urandom), -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
